dcmac_rx_port_arbiter: RTL and testbench

Packet-level round-robin arbiter that merges the two 4-segment RX streams (one per 100GbE port, each produced by a 2-to-4 segment converter) into a single 4-segment stream for the shared downstream packet path. Grants are held for whole packets and re-evaluated only at packet boundaries. Per-port enables allow software to drain and discard a port's traffic cleanly. One registered output stage provides backpressure toward the per-port FIFOs.

---
 rtl/dcmac_rx_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dcmac_rx_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcmac_rx_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dcmac_rx_port_arbiter
//  Purpose  : Packet-level round-robin merge of two 4-segment RX streams into
//             one 4-segment stream. Grants are held for whole packets. A port
//             whose enable is low at selection time is drained: its packet is
//             accepted and discarded, and counted in a saturating counter.
//             A single registered output stage backpressures the sources.
//  Options  : RX_ARB_ERR_DROP_EN - flag the eop cycle of an errored forwarded
//             packet on every active segment and count it as a drop.
//  Revision : 1.0 - initial release
// ============================================================================
module dcmac_rx_port_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   port_enable,
  input  logic [511:0] s0_tdata,
  input  logic [15:0]  s0_tid,
  input  logic [11:0]  s0_tuser,
  input  logic [3:0]   s0_tlast,
  input  logic         s0_tvalid,
  output logic         s0_tready,
  input  logic [511:0] s1_tdata,
  input  logic [15:0]  s1_tid,
  input  logic [11:0]  s1_tuser,
  input  logic [3:0]   s1_tlast,
  input  logic         s1_tvalid,
  output logic         s1_tready,
  output logic [511:0] m_tdata,
  output logic [15:0]  m_tid,
  output logic [11:0]  m_tuser,
  output logic [3:0]   m_tlast,
  output logic         m_tdest,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [15:0]  drop_count0,
  output logic [15:0]  drop_count1
);

  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_grant;
  logic         r_last_grant;

  logic [511:0] r_m_tdata;
  logic [15:0]  r_m_tid;
  logic [11:0]  r_m_tuser;
  logic [3:0]   r_m_tlast;
  logic         r_m_tdest;
  logic         r_m_tvalid;

  logic [15:0]  r_drop_count0;
  logic [15:0]  r_drop_count1;

  // Granted-port view of the input streams
  logic [511:0] w_sel_tdata;
  logic [15:0]  w_sel_tid;
  logic [11:0]  w_sel_tuser;
  logic [3:0]   w_sel_tlast;
  logic         w_sel_tvalid;

  logic [11:0]  w_out_tuser;
  logic         w_fwd_err;
  logic         w_grant_ready;
  logic         w_xfer;
  logic         w_eop;
  logic [1:0]   w_req;
  logic         w_pick;
  logic         w_inc0;
  logic         w_inc1;

  assign w_sel_tdata  = r_grant ? s1_tdata  : s0_tdata;
  assign w_sel_tid    = r_grant ? s1_tid    : s0_tid;
  assign w_sel_tuser  = r_grant ? s1_tuser  : s0_tuser;
  assign w_sel_tlast  = r_grant ? s1_tlast  : s0_tlast;
  assign w_sel_tvalid = r_grant ? s1_tvalid : s0_tvalid;

  // FWD accepts only when the output register is free or emptying this cycle;
  // DRAIN always accepts; IDLE never accepts (selection cycle).
  assign w_grant_ready = (r_state == ST_FWD)   ? (~r_m_tvalid | m_tready) :
                         (r_state == ST_DRAIN);

  assign s0_tready = w_grant_ready & ~r_grant;
  assign s1_tready = w_grant_ready &  r_grant;

  assign w_xfer = w_sel_tvalid & w_grant_ready;
  assign w_eop  = w_xfer & (|w_sel_tlast);

  // Round robin: on a tie the port that did not go last wins
  assign w_req  = {s1_tvalid, s0_tvalid};
  assign w_pick = (&w_req) ? ~r_last_grant : w_req[1];

`ifdef RX_ARB_ERR_DROP_EN
  logic [3:0] w_seg_err;
  logic [3:0] w_seg_ena;
  logic       w_eop_err;

  // Error on the eop segment is propagated to every active segment of that cycle
  for (genvar k = 0; k < 4; k++) begin : g_seg
    assign w_seg_err[k]             = w_sel_tuser[3*k];
    assign w_seg_ena[k]             = w_sel_tuser[3*k+2];
    assign w_out_tuser[3*k+2:3*k+1] = w_sel_tuser[3*k+2:3*k+1];
    assign w_out_tuser[3*k]         = w_sel_tuser[3*k] | (w_eop_err & w_seg_ena[k]);
  end

  assign w_eop_err = |(w_sel_tlast & w_seg_err);
  assign w_fwd_err = w_eop_err;
`else
  assign w_out_tuser = w_sel_tuser;
  assign w_fwd_err   = 1'b0;
`endif

  // A packet is counted as dropped when drained, or forwarded with an error
  // when error dropping is built in.
  assign w_inc0 = w_eop & ~r_grant &
                  ((r_state == ST_DRAIN) | ((r_state == ST_FWD) & w_fwd_err));
  assign w_inc1 = w_eop &  r_grant &
                  ((r_state == ST_DRAIN) | ((r_state == ST_FWD) & w_fwd_err));

  // Arbitration FSM: select at IDLE, hold grant until the eop transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_state <= port_enable[w_pick] ? ST_FWD : ST_DRAIN;
          end
        end
        ST_FWD, ST_DRAIN: begin
          if (w_eop) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on forwarded transfers, empty when accepted downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
      r_m_tuser  <= '0;
      r_m_tlast  <= '0;
      r_m_tdest  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if ((r_state == ST_FWD) && w_xfer) begin
      r_m_tdata  <= w_sel_tdata;
      r_m_tid    <= w_sel_tid;
      r_m_tuser  <= w_out_tuser;
      r_m_tlast  <= w_sel_tlast;
      r_m_tdest  <= r_grant;
      r_m_tvalid <= 1'b1;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Saturating per-port drop counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_count0 <= '0;
      r_drop_count1 <= '0;
    end else begin
      if (w_inc0 && (r_drop_count0 != c_CNT_MAX)) r_drop_count0 <= r_drop_count0 + 16'd1;
      if (w_inc1 && (r_drop_count1 != c_CNT_MAX)) r_drop_count1 <= r_drop_count1 + 16'd1;
    end
  end

  assign m_tdata     = r_m_tdata;
  assign m_tid       = r_m_tid;
  assign m_tuser     = r_m_tuser;
  assign m_tlast     = r_m_tlast;
  assign m_tdest     = r_m_tdest;
  assign m_tvalid    = r_m_tvalid;
  assign drop_count0 = r_drop_count0;
  assign drop_count1 = r_drop_count1;

endmodule
`default_nettype wire

// File: tb/tb_dcmac_rx_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcmac_rx_port_arbiter
//  Purpose  : Self-checking bench for dcmac_rx_port_arbiter: a per-cycle
//             vector table for two-port round robin, plus directed sequences
//             for drain, backpressure, enable change, reset and saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dcmac_rx_port_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   port_enable = 2'b11;
  logic [511:0] s0_tdata = '0, s1_tdata = '0;
  logic [15:0]  s0_tid = '0, s1_tid = '0;
  logic [11:0]  s0_tuser = '0, s1_tuser = '0;
  logic [3:0]   s0_tlast = '0, s1_tlast = '0;
  logic         s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic         s0_tready, s1_tready;
  logic [511:0] m_tdata;
  logic [15:0]  m_tid;
  logic [11:0]  m_tuser;
  logic [3:0]   m_tlast;
  logic         m_tdest, m_tvalid;
  logic         m_tready = 1'b1;
  logic [15:0]  drop_count0, drop_count1;

  int checks = 0;
  int errors = 0;

  logic [28:0] act_q[$];
  logic [28:0] exp_q[$];

  dcmac_rx_port_arbiter dut (
    .clk(clk), .reset(reset), .port_enable(port_enable),
    .s0_tdata(s0_tdata), .s0_tid(s0_tid), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tid(s1_tid), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tid(m_tid), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .drop_count0(drop_count0), .drop_count1(drop_count1)
  );

  always #5 clk = ~clk;

  // Capture every beat accepted downstream: {dest, tuser, tag}
  always @(negedge clk) begin
    #2;
    if (m_tvalid && m_tready && !reset)
      act_q.push_back({m_tdest, m_tuser, m_tdata[15:0]});
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic v, input logic [15:0] tag,
                            input logic last, input logic [11:0] tu);
    if (p == 0) begin
      s0_tvalid = v; s0_tdata = {496'd0, tag}; s0_tlast = last ? 4'b0001 : 4'b0000;
      s0_tuser = tu; s0_tid = {12'd0, tag[3:0]};
    end else begin
      s1_tvalid = v; s1_tdata = {496'd0, tag}; s1_tlast = last ? 4'b0001 : 4'b0000;
      s1_tuser = tu; s1_tid = {12'd0, tag[3:0]};
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? s0_tready : s1_tready;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive_port(0, 1'b0, 16'h0, 1'b0, 12'h0);
    drive_port(1, 1'b0, 16'h0, 1'b0, 12'h0);
    m_tready = 1'b1;
    port_enable = 2'b11;
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s0_tready", s0_tready, 0);
    check("rst_s1_tready", s1_tready, 0);
    check("rst_m_tdata", {31'd0, |m_tdata}, 0);
    check("rst_m_tdest", m_tdest, 0);
    check("rst_drop0", drop_count0, 0);
    check("rst_drop1", drop_count1, 0);
    @(negedge clk);
    reset = 1'b0;
    act_q.delete();
    exp_q.delete();
  endtask

  // Present one packet on port p, honouring tready; optional downstream
  // stall before beat stall_beat and enable clear while presenting clr_beat.
  task automatic send_pkt(input int p, input int nbeats, input logic [15:0] base,
                          input bit fwd, input bit err, input int stall_beat,
                          input int stall_len, input int clr_beat);
    int stalls;
    int waited;
    bit done;
    logic last;
    logic [11:0] tu;
    stalls = 0;
    for (int b = 0; b < nbeats; b++) begin
      waited = 0;
      done = 1'b0;
      last = (b == nbeats - 1);
      tu = (last && err) ? 12'h805 : 12'h804;
      while (!done) begin
        @(negedge clk);
        drive_port(p, 1'b1, base + 16'(b), last, tu);
        if (b == clr_beat) port_enable[p] = 1'b0;
        if (b == stall_beat && stalls < stall_len) begin
          m_tready = 1'b0;
          stalls++;
        end else begin
          m_tready = 1'b1;
        end
        #1;
        if (!m_tready) begin
          check("stall_ready", port_ready(p), 0);
          check("stall_valid", m_tvalid, 1);
          check("stall_hold", m_tdata[15:0], base + 16'(b) - 16'd1);
        end else if (b > 0 && waited == 0) begin
          check("mid_pkt_ready", port_ready(p), 1);
        end
        if (!fwd) check("drain_no_out", m_tvalid, 0);
        if (port_ready(p)) begin
          done = 1'b1;
          if (fwd) begin
`ifdef RX_ARB_ERR_DROP_EN
            exp_q.push_back({p[0], (last && err) ? 12'hA05 : tu, base + 16'(b)});
`else
            exp_q.push_back({p[0], tu, base + 16'(b)});
`endif
          end
        end else begin
          waited++;
          if (waited > 20) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout actual=no_tready required=tready port=%0d beat=%0d", p, b);
            done = 1'b1;
          end
        end
      end
    end
    @(negedge clk);
    drive_port(p, 1'b0, 16'h0, 1'b0, 12'h0);
  endtask

  task automatic compare_sb(input string name);
    repeat (3) @(negedge clk);
    check({name, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      check({name, "_beat"}, {3'd0, act_q[i]}, {3'd0, exp_q[i]});
  endtask

  typedef struct {
    logic        s0v;
    logic [15:0] s0tag;
    logic        s0l;
    logic        s1v;
    logic [15:0] s1tag;
    logic        s1l;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_mv;
    logic        e_md;
    logic [15:0] e_tag;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Both ports always requesting, 3-beat packets, m_tready=1.
    // Tag = {port, packet, beat}. Expected outputs are for the cycle in which
    // the row's inputs are presented (registered outputs from earlier edges).
    vecs[0]  = '{1, 16'h000, 0, 1, 16'h100, 0,  0, 0, 0, 0, 16'h000};
    vecs[1]  = '{1, 16'h000, 0, 1, 16'h100, 0,  1, 0, 0, 0, 16'h000};
    vecs[2]  = '{1, 16'h001, 0, 1, 16'h100, 0,  1, 0, 1, 0, 16'h000};
    vecs[3]  = '{1, 16'h002, 1, 1, 16'h100, 0,  1, 0, 1, 0, 16'h001};
    vecs[4]  = '{1, 16'h010, 0, 1, 16'h100, 0,  0, 0, 1, 0, 16'h002};
    vecs[5]  = '{1, 16'h010, 0, 1, 16'h100, 0,  0, 1, 0, 0, 16'h002};
    vecs[6]  = '{1, 16'h010, 0, 1, 16'h101, 0,  0, 1, 1, 1, 16'h100};
    vecs[7]  = '{1, 16'h010, 0, 1, 16'h102, 1,  0, 1, 1, 1, 16'h101};
    vecs[8]  = '{1, 16'h010, 0, 1, 16'h110, 0,  0, 0, 1, 1, 16'h102};
    vecs[9]  = '{1, 16'h010, 0, 1, 16'h110, 0,  1, 0, 0, 1, 16'h102};
    vecs[10] = '{1, 16'h011, 0, 1, 16'h110, 0,  1, 0, 1, 0, 16'h010};
    vecs[11] = '{1, 16'h012, 1, 1, 16'h110, 0,  1, 0, 1, 0, 16'h011};
    vecs[12] = '{1, 16'h020, 0, 1, 16'h110, 0,  0, 0, 1, 0, 16'h012};
    vecs[13] = '{1, 16'h020, 0, 1, 16'h110, 0,  0, 1, 0, 0, 16'h012};
    vecs[14] = '{1, 16'h020, 0, 1, 16'h111, 0,  0, 1, 1, 1, 16'h110};

    do_reset();

    // Round-robin table
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_port(0, vecs[i].s0v, vecs[i].s0tag, vecs[i].s0l, 12'h000);
      drive_port(1, vecs[i].s1v, vecs[i].s1tag, vecs[i].s1l, 12'h000);
      m_tready = 1'b1;
      #1;
      check($sformatf("rr%0d_s0_tready", i), s0_tready, vecs[i].e_s0r);
      check($sformatf("rr%0d_s1_tready", i), s1_tready, vecs[i].e_s1r);
      check($sformatf("rr%0d_m_tvalid", i), m_tvalid, vecs[i].e_mv);
      check($sformatf("rr%0d_m_tdest", i), m_tdest, vecs[i].e_md);
      check($sformatf("rr%0d_m_tag", i), m_tdata[15:0], vecs[i].e_tag);
    end

    // Port 1 disabled: its packets are drained and counted
    do_reset();
    port_enable = 2'b01;
    for (int n = 0; n < 3; n++) begin
      send_pkt(1, 3, 16'h0100 + 16'(n * 16), 1'b0, 1'b0, -1, 0, -1);
      #1;
      check("drain_count1", drop_count1, n + 1);
      check("drain_count0", drop_count0, 0);
    end
    compare_sb("drain_sb");

    // Downstream stall of 5 cycles in the middle of a forwarded packet
    do_reset();
    send_pkt(0, 4, 16'h0200, 1'b1, 1'b1, 2, 5, -1);
    compare_sb("stall_sb");
`ifdef RX_ARB_ERR_DROP_EN
    check("err_drop0", drop_count0, 1);
`else
    check("err_drop0", drop_count0, 0);
`endif

    // Enable cleared mid-packet: current packet completes, next one is drained
    do_reset();
    send_pkt(0, 4, 16'h0300, 1'b1, 1'b0, -1, 0, 1);
    send_pkt(0, 2, 16'h0310, 1'b0, 1'b0, -1, 0, -1);
    #1;
    check("en_change_drop0", drop_count0, 1);
    compare_sb("en_change_sb");

    // Reset in the middle of a forwarded packet
    do_reset();
    @(negedge clk);
    drive_port(0, 1'b1, 16'h0400, 1'b0, 12'h004);
    @(negedge clk);
    @(negedge clk);
    drive_port(0, 1'b1, 16'h0401, 1'b0, 12'h004);
    #1;
    check("pre_reset_valid", m_tvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_s0_tready", s0_tready, 0);
    check("midrst_m_tag", m_tdata[15:0], 0);
    check("midrst_m_tuser", m_tuser, 0);
    @(negedge clk);
    reset = 1'b0;
    drive_port(1, 1'b1, 16'h0500, 1'b0, 12'h004);
    @(negedge clk);
    #1;
    check("postrst_tie_s0", s0_tready, 1);
    check("postrst_tie_s1", s1_tready, 0);

    // Drop counter saturation (counter preloaded near its limit)
    do_reset();
    port_enable = 2'b10;
    @(negedge clk);
    force dut.r_drop_count0 = 16'hFFFC;
    #1;
    release dut.r_drop_count0;
    for (int n = 0; n < 5; n++) begin
      send_pkt(0, 1, 16'h0600 + 16'(n), 1'b0, 1'b0, -1, 0, -1);
      #1;
      check("sat_drop0", drop_count0, (n < 3) ? 32'hFFFD + n : 32'hFFFF);
    end
    check("sat_drop1", drop_count1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
